// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit producing a HI/LO pair.
// Multiplies use a MUL_LATENCY-stage registered pipeline. Divides use a
// radix-2 restoring loop on operand magnitudes, followed by a sign-fix cycle.
// Optional build macro MDU_EARLY_OUT_EN: a divide by zero, or one with
// |a| < |b|, skips the iteration loop and completes two cycles after start.
module mdu_iter #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1) + 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic               early_q, early_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               accept, abort, mul_last, div_last, early_hit, trial_ge;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, prod, mul_res;

  // Start/abort qualification and the signed-magnitude operand views.
  always_comb begin
    accept   = start && !cancel && (state_q == S_IDLE);
    abort    = cancel && (state_q != S_IDLE);
    mul_last = (cnt_q == CW'(MUL_LATENCY - 1));
    mag_a    = (!op[0] && a[WIDTH-1]) ? -a : a;
    mag_b    = (!op[0] && b[WIDTH-1]) ? -b : b;
`ifdef MDU_EARLY_OUT_EN
    early_hit = op[1] && ((b == '0) || (mag_a < mag_b));
`else
    early_hit = 1'b0;
`endif
    div_last  = early_q || (cnt_q == CW'(WIDTH - 1));
    // One restoring step: shift the next dividend bit into the partial remainder.
    trial     = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    trial_ge  = !trial[WIDTH];
    mul_a_ext = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    mul_b_ext = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod      = mul_a_ext * mul_b_ext;
  end

  // Multiply pipeline: the product of the registered operands travels
  // through MUL_LATENCY-1 stages before being committed to HI/LO.
  generate
    if (MUL_LATENCY == 1) begin : g_nopipe
      assign mul_res = prod;
    end else begin : g_pipe
      logic [2*WIDTH-1:0] pipe_q [MUL_LATENCY-1];
      // Shift the product pipeline while a multiply is in flight.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < MUL_LATENCY - 1; i++) pipe_q[i] <= '0;
        end else if (state_q == S_MUL) begin
          pipe_q[0] <= prod;
          for (int i = 1; i < MUL_LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign mul_res = pipe_q[MUL_LATENCY-2];
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic; an abort always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = op[1] ? S_DIV : S_MUL;
      S_MUL:  if (mul_last) state_d = S_IDLE;
      S_DIV:  if (div_last) state_d = S_FIX;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // FSM outputs: busy for the whole flight, done/HI/LO straight from flops.
  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  // Datapath next-state: operand capture, counter, divide step, result commit.
  always_comb begin
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    early_d = early_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (accept) begin
      sgn_d   = !op[0];
      early_d = early_hit;
      a_d     = a;
      b_d     = b;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = mag_a;
      dvs_d   = mag_b;
    end else if (abort) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        S_MUL: begin
          cnt_d = cnt_q + 1'b1;
          if (mul_last) begin
            cnt_d        = '0;
            done_d       = 1'b1;
            {hi_d, lo_d} = mul_res;
          end
        end
        S_DIV: begin
          cnt_d = div_last ? '0 : cnt_q + 1'b1;
          rem_d = trial_ge ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], trial_ge};
        end
        S_FIX: begin
          done_d = 1'b1;
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else if (early_q) begin
            lo_d = '0;
            hi_d = a_q;
          end else begin
            // Quotient negative when operand signs differ; remainder follows dividend.
            lo_d = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_q : quo_q;
            hi_d = (sgn_q && a_q[WIDTH-1]) ? -rem_q : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      early_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      early_q <= early_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
